// File: rtl/filter_loader.sv
// filter_loader: fetches NWORDS 32-bit words from external memory into a 16-byte filter buffer.
// Optional byte checksum on the cksum port when FILTER_LOADER_CKSUM_EN is defined.
module filter_loader #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned NWORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              buf_wr_en,
  output logic [3:0]        buf_wr_addr,
  output logic [31:0]       buf_wr_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        cksum
);

  localparam int unsigned IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned LAST  = NWORDS - 1;

  // One-hot encoding so every control output is a direct flop bit decode
  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_REQ  = 4'b0010,
    S_WR   = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic              w_accept;
  logic              w_capture;
  logic              w_advance;
  logic              w_last;

  assign w_last    = (r_idx == IDX_W'(LAST));
  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_capture = (r_state == S_REQ) && mem_ack && !abort;
  assign w_advance = (r_state == S_WR) && !abort && !w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Abort wins over mem_ack and over the WR->REQ/DONE step
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_REQ;
      S_REQ: begin
        if (abort)        w_next = S_IDLE;
        else if (mem_ack) w_next = S_WR;
      end
      S_WR: begin
        if (abort)       w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
        else             w_next = S_REQ;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    buf_wr_en = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE:  busy      = 1'b0;
      S_REQ:   mem_req   = 1'b1;
      S_WR:    buf_wr_en = 1'b1;
      S_DONE:  done      = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  // Word address advances by 4 after each write; wraps modulo 2^ADDR_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      if (w_accept) begin
        r_idx  <= '0;
        r_addr <= base_addr;
      end else if (w_advance) begin
        r_idx  <= r_idx + IDX_W'(1);
        r_addr <= r_addr + ADDR_W'(4);
      end
      if (w_capture) r_data <= mem_rdata;
    end
  end

  assign mem_addr    = r_addr;
  assign buf_wr_addr = 4'({r_idx, 2'b00});
  assign buf_wr_data = r_data;

`ifdef FILTER_LOADER_CKSUM_EN
  logic [7:0] r_cksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cksum <= '0;
    else if (w_accept)         r_cksum <= '0;
    else if (r_state == S_WR)  r_cksum <= r_cksum + r_data[31:24] + r_data[23:16]
                                                  + r_data[15:8]  + r_data[7:0];
  end

  assign cksum = r_cksum;
`else
  assign cksum = 8'h00;
`endif

endmodule

// File: tb/tb_filter_loader.sv
// Bench for filter_loader: schedule-based expected-output model plus directed literal checks.
module tb_filter_loader;

  localparam int NW  = 4;
  localparam int INF = 1 << 30;

`ifdef FILTER_LOADER_CKSUM_EN
  localparam logic [7:0] CK_FULL = 8'h88;
  localparam logic [7:0] CK_W0   = 8'h0A;
`else
  localparam logic [7:0] CK_FULL = 8'h00;
  localparam logic [7:0] CK_W0   = 8'h00;
`endif

  typedef struct packed {
    logic        rst;
    logic        req;
    logic [15:0] addr;
    logic        wr;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [7:0]  ck;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] base_addr;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        buf_wr_en;
  logic [3:0]  buf_wr_addr;
  logic [31:0] buf_wr_data;
  logic        busy;
  logic        done;
  logic [7:0]  cksum;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;
  int          wcnt = 0;
  logic        spur;

  // Current load scenario, in absolute cycle numbers
  int          sc_start, sc_delay, sc_abort, sc_rst;
  logic [15:0] sc_base;
  logic [7:0]  held_ck;
  exp_t        ce;

  filter_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .busy(busy), .done(done), .cksum(cksum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word_at(input logic [15:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {8'(b + 8'd1), 8'(b + 8'd2), 8'(b + 8'd3), 8'(b + 8'd4)};
  endfunction

  function automatic logic [7:0] bsum(input logic [31:0] w);
    return 8'(w[31:24] + w[23:16] + w[15:8] + w[7:0]);
  endfunction

  // Word k is requested from s+1+k*(d+2) for d+1 cycles, written next cycle; done after the last write
  function automatic exp_t exp_at(input int c);
    exp_t        e;
    int          per, ph, w, off, lim, tw;
    logic [7:0]  ck;
    logic [15:0] a;
    e   = '0;
    per = sc_delay + 2;
    lim = INF;
    if (c >= sc_rst) begin
      e.rst = 1'b1;
      return e;
    end
    e.ck = held_ck;
    if (c > sc_start) begin
      if (sc_abort > sc_start && (sc_abort - sc_start - 1) / per < NW) lim = sc_abort;
      ck = 8'h00;
      for (int k = 0; k < NW; k++) begin
        tw = sc_start + 2 + k * per + sc_delay;
        if (tw < c && tw <= lim) ck = 8'(ck + bsum(word_at(16'(int'(sc_base) + 4 * k))));
      end
      e.ck = ck;
      if (c <= lim) begin
        ph  = c - sc_start - 1;
        w   = ph / per;
        off = ph % per;
        if (w < NW) begin
          e.busy = 1'b1;
          a = 16'(int'(sc_base) + 4 * w);
          if (off <= sc_delay) begin
            e.req  = 1'b1;
            e.addr = a;
          end else begin
            e.wr    = 1'b1;
            e.waddr = 4'(4 * w);
            e.wdata = word_at(a);
          end
        end else if (w == NW && off == 0) begin
          e.busy = 1'b1;
          e.done = 1'b1;
        end
      end
    end
`ifndef FILTER_LOADER_CKSUM_EN
    e.ck = 8'h00;
`endif
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic to_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_load(input int s, input int d, input logic [15:0] b, input int a, input logic sp);
    exp_t prev;
    to_cycle(s);
    prev     = exp_at(s);
    held_ck  = prev.ck;
    sc_start = s;
    sc_delay = d;
    sc_base  = b;
    sc_abort = a;
    sc_rst   = INF;
    spur     = sp;
    start     = 1'b1;
    base_addr = b;
    to_cycle(s + 1);
    start     = 1'b0;
    base_addr = ~b;
  endtask

  // Memory responder: acks after sc_delay wait cycles; optional stray acks outside REQ
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      if (wcnt >= sc_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = word_at(mem_addr);
        wcnt      = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        wcnt++;
      end
    end else begin
      wcnt      = 0;
      mem_ack   = spur;
      mem_rdata = spur ? 32'hDEADBEEF : 32'h0;
    end
  end

  // Per-cycle comparison against the schedule model
  always @(negedge clk) begin
    if (cyc > 0) begin
      ce = exp_at(cyc);
      check("mem_req", 32'(mem_req), 32'(ce.req));
      check("buf_wr_en", 32'(buf_wr_en), 32'(ce.wr));
      check("busy", 32'(busy), 32'(ce.busy));
      check("done", 32'(done), 32'(ce.done));
      check("cksum", 32'(cksum), 32'(ce.ck));
      check("excl", 32'((mem_req & buf_wr_en) | (mem_req & done) | (buf_wr_en & done)), 32'(0));
      if (ce.req) check("mem_addr", 32'(mem_addr), 32'(ce.addr));
      if (ce.wr) begin
        check("buf_wr_addr", 32'(buf_wr_addr), 32'(ce.waddr));
        check("buf_wr_data", buf_wr_data, ce.wdata);
      end
      if (ce.rst) begin
        check("rst_mem_addr", 32'(mem_addr), 32'(0));
        check("rst_wr_addr", 32'(buf_wr_addr), 32'(0));
        check("rst_wr_data", buf_wr_data, 32'(0));
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = 16'h0; spur = 1'b0;
    sc_start = INF; sc_delay = 0; sc_abort = INF; sc_rst = 0; sc_base = 16'h0; held_ck = 8'h00;

    to_cycle(1);
    @(negedge clk);
    check("lit_reset_busy", 32'(busy), 32'(0));
    check("lit_reset_cksum", 32'(cksum), 32'(0));
    to_cycle(2);
    rst_n  = 1'b1;
    sc_rst = INF;

    // Zero-wait load from 0x0100
    run_load(5, 0, 16'h0100, INF, 1'b0);
    @(negedge clk);
    check("lit_a_req", 32'(mem_req), 32'(1));
    check("lit_a_addr", 32'(mem_addr), 32'h0100);
    to_cycle(7);
    @(negedge clk);
    check("lit_a_wr", 32'(buf_wr_en), 32'(1));
    check("lit_a_wdata", buf_wr_data, 32'h01020304);
    to_cycle(14);
    @(negedge clk);
    check("lit_a_done", 32'(done), 32'(1));
    check("lit_a_cksum", 32'(cksum), 32'(CK_FULL));
    to_cycle(15);
    @(negedge clk);
    check("lit_a_idle", 32'(busy), 32'(0));

    // Three wait cycles per word with stray acks outside REQ
    run_load(20, 3, 16'h0200, INF, 1'b1);
    to_cycle(22);
    @(negedge clk);
    check("lit_b_addr_wait", 32'(mem_addr), 32'h0200);
    to_cycle(41);
    @(negedge clk);
    check("lit_b_done", 32'(done), 32'(1));
    to_cycle(44);
    spur = 1'b0;

    // Address wrap, starts ignored mid-load and in DONE, abort in DONE ignored
    run_load(50, 0, 16'hFFF8, 59, 1'b0);
    to_cycle(53);
    start = 1'b1;
    to_cycle(54);
    start = 1'b0;
    to_cycle(55);
    @(negedge clk);
    check("lit_c_wrap", 32'(mem_addr), 32'h0000);
    to_cycle(59);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    check("lit_c_done", 32'(done), 32'(1));
    to_cycle(60);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("lit_c_idle", 32'(busy), 32'(0));

    // Abort together with the second mem_ack
    run_load(65, 0, 16'h0100, 68, 1'b0);
    to_cycle(68);
    abort = 1'b1;
    to_cycle(69);
    abort = 1'b0;
    @(negedge clk);
    check("lit_d_idle", 32'(busy), 32'(0));
    check("lit_d_cksum", 32'(cksum), 32'(CK_W0));

    // Normal load after the abort
    run_load(72, 1, 16'h0300, INF, 1'b0);
    to_cycle(85);
    @(negedge clk);
    check("lit_e_done", 32'(done), 32'(1));

    // Reset during the third REQ
    run_load(90, 0, 16'h0100, INF, 1'b0);
    to_cycle(95);
    rst_n  = 1'b0;
    sc_rst = 95;
    @(negedge clk);
    check("lit_f_req", 32'(mem_req), 32'(0));
    check("lit_f_addr", 32'(mem_addr), 32'(0));
    check("lit_f_cksum", 32'(cksum), 32'(0));
    to_cycle(97);
    rst_n = 1'b1;

    // Clean load after reset
    run_load(100, 0, 16'h0400, INF, 1'b0);
    to_cycle(109);
    @(negedge clk);
    check("lit_g_done", 32'(done), 32'(1));
    check("lit_g_cksum", 32'(cksum), 32'(CK_FULL));
    to_cycle(115);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
